// File: rtl/vdu_pkg.sv
// Shared types and constants for the bitmap VDU family.
//   rgb565_t      : packed RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   cfg_sel_t     : colour register selector
//   axis_timing_t : active/porch/sync widths for one display axis
//   axis_total()  : total count (active + porches + sync) of one axis
package vdu_pkg;

    localparam int CW = 16;
    typedef logic [CW-1:0] coord_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        CFG_FG     = 2'd0,
        CFG_BG     = 2'd1,
        CFG_BORDER = 2'd2
    } cfg_sel_t;

    localparam rgb565_t FG_DEFAULT     = rgb565_t'(16'hF600);  // yellow
    localparam rgb565_t BG_DEFAULT     = rgb565_t'(16'h10CE);  // blue
    localparam rgb565_t BORDER_DEFAULT = rgb565_t'(16'h0000);  // black
    localparam rgb565_t BLACK          = rgb565_t'(16'h0000);

    typedef struct packed {
        coord_t res;
        coord_t fp;
        coord_t sync;
        coord_t bp;
    } axis_timing_t;

    function automatic coord_t axis_total(input axis_timing_t t);
        return t.res + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vdu_vga_bitmap_timing.sv
// display_timing: raster position counters and raw (active-high) timing.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   sx_o, sy_o           : current beam position
//   sx_next_o, sy_next_o : position the counters move to on the next edge
//   hsync_o, vsync_o     : sync windows, active-high regardless of pin polarity
//   de_o                 : inside the active area
//   frame_o, line_o      : position is (0,0) / sx is 0
module display_timing
    import vdu_pkg::*;
#(
    parameter axis_timing_t H_TIM = '{16'd800, 16'd40, 16'd128, 16'd88},
    parameter axis_timing_t V_TIM = '{16'd600, 16'd1, 16'd4, 16'd23}
) (
    input  logic   clk_i,
    input  logic   rst_i,
    output coord_t sx_o,
    output coord_t sy_o,
    output coord_t sx_next_o,
    output coord_t sy_next_o,
    output logic   hsync_o,
    output logic   vsync_o,
    output logic   de_o,
    output logic   frame_o,
    output logic   line_o
);

    localparam coord_t H_LAST = axis_total(H_TIM) - 16'd1;
    localparam coord_t V_LAST = axis_total(V_TIM) - 16'd1;
    localparam coord_t HS_BEG = H_TIM.res + H_TIM.fp;
    localparam coord_t HS_END = H_TIM.res + H_TIM.fp + H_TIM.sync;
    localparam coord_t VS_BEG = V_TIM.res + V_TIM.fp;
    localparam coord_t VS_END = V_TIM.res + V_TIM.fp + V_TIM.sync;

    coord_t sx_q, sy_q, sx_d, sy_d;

    // Next raster position: sx wraps each line, sy advances on that wrap
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (sx_q == H_LAST) begin
            sx_d = 16'd0;
            if (sy_q == V_LAST) begin
                sy_d = 16'd0;
            end else begin
                sy_d = sy_q + 16'd1;
            end
        end else begin
            sx_d = sx_q + 16'd1;
        end
    end

    // Raster position registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sx_q <= 16'd0;
            sy_q <= 16'd0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    assign sx_o      = sx_q;
    assign sy_o      = sy_q;
    assign sx_next_o = sx_d;
    assign sy_next_o = sy_d;
    assign hsync_o   = (sx_q >= HS_BEG) && (sx_q < HS_END);
    assign vsync_o   = (sy_q >= VS_BEG) && (sy_q < VS_END);
    assign de_o      = (sx_q < H_TIM.res) && (sy_q < V_TIM.res);
    assign line_o    = (sx_q == 16'd0);
    assign frame_o   = (sx_q == 16'd0) && (sy_q == 16'd0);

endmodule

// File: rtl/vdu_vga_bitmap.sv
// vdu_vga_bitmap: centred, pixel-replicated 1-bpp bitmap on a VGA raster.
//   clk_pix, rst_pix            : pixel clock, synchronous active-high reset
//   en                          : display enable, taken at frame start
//   cfg_we/cfg_sel/cfg_data     : colour shadow register write port (RGB565)
//   read_en/read_addr           : display memory byte fetch
//   display_data                : fetched byte, READ_LAT cycles after read_en
//   frame_start                 : pulse with the first active pixel on the pins
//   vga_*                       : registered VGA pins, one cycle behind counters
module vdu_vga_bitmap
    import vdu_pkg::*;
#(
    parameter int H_RES     = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_RES     = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int H_POL     = 1,
    parameter int V_POL     = 1,
    parameter int BM_W      = 64,
    parameter int BM_H      = 64,
    parameter int SCALE     = 3,
    parameter int BASE_ADDR = 0,
    parameter int READ_LAT  = 1
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic        en,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic [15:0] cfg_data,
    output logic        read_en,
    output logic [15:0] read_addr,
    input  logic [7:0]  display_data,
    output logic        frame_start,
    output logic        vga_clk,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [4:0]  vga_r,
    output logic [5:0]  vga_g,
    output logic [4:0]  vga_b
);

    localparam int WIN_W = BM_W << SCALE;
    localparam int WIN_H = BM_H << SCALE;
    localparam int X_OFF = (H_RES - WIN_W) / 2;
    localparam int Y_OFF = (V_RES - WIN_H) / 2;

    localparam coord_t X0        = coord_t'(X_OFF);
    localparam coord_t X1        = coord_t'(X_OFF + WIN_W);
    localparam coord_t Y0        = coord_t'(Y_OFF);
    localparam coord_t Y1        = coord_t'(Y_OFF + WIN_H);
    localparam coord_t LEAD      = coord_t'(READ_LAT + 1);
    localparam coord_t PIX_MASK  = coord_t'((1 << SCALE) - 1);
    localparam coord_t BYTE_MASK = coord_t'((8 << SCALE) - 1);
    localparam coord_t ROW_BYTES = coord_t'(BM_W / 8);
    localparam logic [15:0] BASE16 = 16'(BASE_ADDR);
    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    localparam axis_timing_t H_TIM = '{coord_t'(H_RES), coord_t'(H_FP), coord_t'(H_SYNC), coord_t'(H_BP)};
    localparam axis_timing_t V_TIM = '{coord_t'(V_RES), coord_t'(V_FP), coord_t'(V_SYNC), coord_t'(V_BP)};

    // The fetch is issued READ_LAT+1 pixels ahead of its byte, so the window
    // must leave that much room after sx=0.
    if ((X_OFF < READ_LAT + 1) || (WIN_W > H_RES) || (WIN_H > V_RES) ||
        (READ_LAT < 1) || (READ_LAT > 4) || ((BM_W % 8) != 0)) begin : g_bad_geometry
        $error("vdu_vga_bitmap: invalid window geometry or READ_LAT");
    end

    coord_t sx_s, sy_s, sx_next_s, sy_next_s;
    logic   hsync_s, vsync_s, de_s, frame_s, line_s;

    display_timing #(
        .H_TIM (H_TIM),
        .V_TIM (V_TIM)
    ) u_timing (
        .clk_i     (clk_pix),
        .rst_i     (rst_pix),
        .sx_o      (sx_s),
        .sy_o      (sy_s),
        .sx_next_o (sx_next_s),
        .sy_next_o (sy_next_s),
        .hsync_o   (hsync_s),
        .vsync_o   (vsync_s),
        .de_o      (de_s),
        .frame_o   (frame_s),
        .line_o    (line_s)
    );

    rgb565_t fg_sh_q, bg_sh_q, bd_sh_q, fg_sh_d, bg_sh_d, bd_sh_d;
    rgb565_t fg_q, bg_q, bd_q, fg_d, bg_d, bd_d;
    logic    en_q, en_d;

    // Shadow writes; shadows (with any same-cycle write) go live at (0,0).
    // The colour mux uses the *_d values so pixel (0,0) already sees them.
    always_comb begin
        fg_sh_d = fg_sh_q;
        bg_sh_d = bg_sh_q;
        bd_sh_d = bd_sh_q;
        if (cfg_we) begin
            case (cfg_sel_t'(cfg_sel))
                CFG_FG:     fg_sh_d = rgb565_t'(cfg_data);
                CFG_BG:     bg_sh_d = rgb565_t'(cfg_data);
                CFG_BORDER: bd_sh_d = rgb565_t'(cfg_data);
                default:    fg_sh_d = fg_sh_q;
            endcase
        end else begin
            fg_sh_d = fg_sh_q;
        end
        if (frame_s) begin
            fg_d = fg_sh_d;
            bg_d = bg_sh_d;
            bd_d = bd_sh_d;
            en_d = en;
        end else begin
            fg_d = fg_q;
            bg_d = bg_q;
            bd_d = bd_q;
            en_d = en_q;
        end
    end

    // Colour and enable registers
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            fg_sh_q <= FG_DEFAULT;
            bg_sh_q <= BG_DEFAULT;
            bd_sh_q <= BORDER_DEFAULT;
            fg_q    <= FG_DEFAULT;
            bg_q    <= BG_DEFAULT;
            bd_q    <= BORDER_DEFAULT;
            en_q    <= 1'b0;
        end else begin
            fg_sh_q <= fg_sh_d;
            bg_sh_q <= bg_sh_d;
            bd_sh_q <= bd_sh_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            bd_q    <= bd_d;
            en_q    <= en_d;
        end
    end

    coord_t      fx_s, fpx_s, ppx_s, by_s;
    logic        row_next_s, fetch_s, in_win_next_s, in_win_s;
    logic [15:0] addr_s, read_addr_d, read_addr_q;
    logic [7:0]  shift_d, shift_q;
    logic        read_en_q;
    rgb565_t     pix_d, rgb_q;
    logic        hsync_q, vsync_q, de_q, frame_start_q;

    // Fetch decode works on the next position so read_en lands on sx=S-READ_LAT-1
    always_comb begin
        fx_s          = sx_next_s + LEAD;
        fpx_s         = fx_s - X0;
        ppx_s         = sx_next_s - X0;
        row_next_s    = (sy_next_s >= Y0) && (sy_next_s < Y1);
        by_s          = (sy_next_s - Y0) >> SCALE;
        fetch_s       = en_q && row_next_s && (fx_s >= X0) && (fx_s < X1) &&
                        ((fpx_s & BYTE_MASK) == 16'd0);
        addr_s        = BASE16 + (by_s * ROW_BYTES) + (fpx_s >> (SCALE + 3));
        in_win_next_s = row_next_s && (sx_next_s >= X0) && (sx_next_s < X1);
        in_win_s      = (sx_s >= X0) && (sx_s < X1) && (sy_s >= Y0) && (sy_s < Y1);
        if (fetch_s) begin
            read_addr_d = addr_s;
        end else begin
            read_addr_d = read_addr_q;
        end
    end

    // Shifter: load at each byte start, shift every 2^SCALE pixels, clear per line
    always_comb begin
        if (line_s) begin
            shift_d = 8'd0;
        end else if (in_win_next_s && ((ppx_s & BYTE_MASK) == 16'd0)) begin
            shift_d = display_data;
        end else if (in_win_next_s && ((ppx_s & PIX_MASK) == 16'd0)) begin
            shift_d = {shift_q[6:0], 1'b0};
        end else begin
            shift_d = shift_q;
        end
    end

    // Pixel colour priority: blanking, disabled, border, bitmap bit
    always_comb begin
        pix_d = BLACK;
        if (!de_s) begin
            pix_d = BLACK;
        end else if (!en_d) begin
            pix_d = BLACK;
        end else if (!in_win_s) begin
            pix_d = bd_d;
        end else if (shift_q[7]) begin
            pix_d = fg_d;
        end else begin
            pix_d = bg_d;
        end
    end

    // Fetch, shifter and output pin registers
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            read_en_q     <= 1'b0;
            read_addr_q   <= 16'd0;
            shift_q       <= 8'd0;
            rgb_q         <= BLACK;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            read_en_q     <= fetch_s;
            read_addr_q   <= read_addr_d;
            shift_q       <= shift_d;
            rgb_q         <= pix_d;
            hsync_q       <= hsync_s ? HS_ON : ~HS_ON;
            vsync_q       <= vsync_s ? VS_ON : ~VS_ON;
            de_q          <= de_s;
            frame_start_q <= frame_s;
        end
    end

    assign read_en     = read_en_q;
    assign read_addr   = read_addr_q;
    assign frame_start = frame_start_q;
    assign vga_clk     = clk_pix;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_de      = de_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;

endmodule

// File: tb/tb_vdu_vga_bitmap.sv
// Scoreboard bench for vdu_vga_bitmap on a reduced raster:
// 64x24 active, 80x30 total, 16x8 bitmap scaled x2 at (16,4), READ_LAT=2,
// BASE_ADDR=32, hsync active-high, vsync active-low.
module tb_vdu_vga_bitmap;

    localparam int HT = 80;
    localparam int VT = 30;

    logic        clk;
    logic        rst_pix, en, cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic        read_en, frame_start, vga_clk, vga_hsync, vga_vsync, vga_de;
    logic [15:0] read_addr;
    logic [7:0]  display_data, d1, d2;
    logic [4:0]  vga_r, vga_b;
    logic [5:0]  vga_g;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:255];
    logic [7:0] pattern [0:15] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h55, 8'hAA,
                                   8'h01, 8'h80, 8'hFF, 8'h00, 8'hC3, 8'h18, 8'hE7, 8'h24};

    typedef struct { int x; int y; logic [15:0] a; } rd_t;
    logic [15:0] exp_pix_q [$];
    rd_t         exp_rd_q [$];
    rd_t         rd_item;
    logic [15:0] pix_item;

    int cx = 0, cy = 0, pvx = 0, pvy = 0;
    bit pvalid = 1'b0;

    logic [15:0] m_fg, m_bg, m_bd;
    bit          m_en;

    vdu_vga_bitmap #(
        .H_RES(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_RES(24), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_POL(1), .V_POL(0),
        .BM_W(16), .BM_H(8), .SCALE(1), .BASE_ADDR(32), .READ_LAT(2)
    ) dut (
        .clk_pix(clk), .rst_pix(rst_pix), .en(en),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .read_en(read_en), .read_addr(read_addr), .display_data(display_data),
        .frame_start(frame_start), .vga_clk(vga_clk),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with two cycles of latency; idle slots return a marker byte
    always @(posedge clk) begin
        d1 <= read_en ? mem[read_addr[7:0]] : 8'h3C;
        d2 <= d1;
    end
    assign display_data = d2;

    // Reference raster position; pv* is the position the pins describe
    always @(posedge clk) begin
        if (rst_pix) begin
            cx <= 0; cy <= 0; pvalid <= 1'b0;
        end else begin
            pvx <= cx; pvy <= cy; pvalid <= 1'b1;
            if (cx == HT - 1) begin
                cx <= 0;
                cy <= (cy == VT - 1) ? 0 : cy + 1;
            end else begin
                cx <= cx + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at pin pos (%0d,%0d): got %0h, expected %0h", nm, pvx, pvy, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_colour(input int x, input int y);
        int bx, by;
        logic [7:0] byt;
        if (!m_en) return 16'h0000;
        if (x < 16 || x >= 48 || y < 4 || y >= 20) return m_bd;
        bx  = (x - 16) >> 1;
        by  = (y - 4) >> 1;
        byt = mem[32 + by * 2 + bx / 8];
        return byt[7 - (bx % 8)] ? m_fg : m_bg;
    endfunction

    task automatic push_frame();
        rd_t r;
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 64; x++)
                exp_pix_q.push_back(exp_colour(x, y));
        if (m_en) begin
            for (int y = 4; y < 20; y++)
                for (int k = 0; k < 2; k++) begin
                    r.x = 13 + 16 * k;
                    r.y = y;
                    r.a = 16'(32 + ((y - 4) >> 1) * 2 + k);
                    exp_rd_q.push_back(r);
                end
        end
    endtask

    task automatic wait_pos(input int x, input int y);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(cx == x && cy == y) && n < 5000);
        chk("wait_pos_timeout", n < 5000, 1'b1);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Monitor: pins checked every cycle against the reference position and queues
    always @(negedge clk) begin
        if (pvalid) begin
            chk("hsync", vga_hsync, (pvx >= 68 && pvx < 76));
            chk("vsync", vga_vsync, !(pvy >= 25 && pvy < 27));
            chk("de", vga_de, (pvx < 64 && pvy < 24));
            chk("frame_start", frame_start, (pvx == 0 && pvy == 0));
            if (vga_de) begin
                if (exp_pix_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pix_queue at (%0d,%0d): got empty, expected an entry", pvx, pvy);
                end else begin
                    pix_item = exp_pix_q.pop_front();
                    chk("rgb", {vga_r, vga_g, vga_b}, pix_item);
                end
            end else begin
                chk("rgb_blank", {vga_r, vga_g, vga_b}, 16'h0000);
            end
            if (read_en) begin
                if (exp_rd_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_queue at (%0d,%0d): got unexpected read %0h", cx, cy, read_addr);
                end else begin
                    rd_item = exp_rd_q.pop_front();
                    chk("read_addr", read_addr, rd_item.a);
                    chk("read_sx", cx, rd_item.x);
                    chk("read_sy", cy, rd_item.y);
                end
            end
        end
    end

    initial begin
        rst_pix = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 16; i++) mem[32 + i] = pattern[i];
        m_fg = 16'hF600; m_bg = 16'h10CE; m_bd = 16'h0000; m_en = 1'b0;
        push_frame();                               // frame 0: disabled, black

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_en", read_en, 1'b0);
        chk("rst_read_addr", read_addr, 16'h0000);
        chk("rst_de", vga_de, 1'b0);
        chk("rst_hsync", vga_hsync, 1'b0);
        chk("rst_vsync", vga_vsync, 1'b1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 16'h0000);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("vga_clk", vga_clk, clk);
        @(posedge clk); #1;
        rst_pix = 1'b0;

        wait_pos(0, 24);                            // frame 0 blanking
        en = 1'b1; m_en = 1'b1;
        push_frame();                               // frame 1: defaults

        wait_pos(0, 10);                            // mid frame 1
        cfg_write(2'd0, 16'h07E0);
        cfg_write(2'd3, 16'hFFFF);
        cfg_write(2'd2, 16'hF81F);
        m_fg = 16'h07E0; m_bd = 16'hF81F;
        wait_pos(0, 24);
        push_frame();                               // frame 2: green fg, magenta border

        wait_pos(0, 24);
        m_bg = 16'h001F;
        push_frame();                               // frame 3: bg written at (0,0)
        wait_pos(0, 0);
        cfg_write(2'd1, 16'h001F);

        wait_pos(0, 12);
        en = 1'b0; m_en = 1'b0;
        wait_pos(0, 24);
        push_frame();                               // frame 4: disabled

        wait_pos(0, 24);
        repeat (4) @(posedge clk);
        chk("pix_queue_left", exp_pix_q.size(), 0);
        chk("rd_queue_left", exp_rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vdu_vga_bitmap.md
Name: vdu_vga_bitmap

Overview:
Parametrised bitmap VDU with VGA output for the MK14 display path. It contains its own configurable timing generator, so resolution and sync timing come from parameters rather than a fixed 800x600 core. It fetches a 1-bpp bitmap from display memory with a configurable read latency, scales each bitmap pixel up by a power of two and centres the bitmap on screen. It adds runtime-programmable foreground, background and border colours; colour writes and the enable take effect only at frame boundaries.

Parameters:
H_RES, 800, active pixels per line
H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal porch and sync widths
V_RES, 600, active lines
V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porch and sync widths
H_POL / V_POL, 1 / 1, sync polarity (1 = active-high)
BM_W / BM_H, 64 / 64, bitmap size in pixels; BM_W must be a multiple of 8
SCALE, 3, log2 of the pixel replication factor in both axes
BASE_ADDR, 0, byte address of bitmap pixel (0,0)
READ_LAT, 1, display memory read latency in cycles (1..4)

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  synchronous active-high reset
en  in  1  display enable; sampled at frame boundary
cfg_we  in  1  colour register write strobe
cfg_sel  in  2  colour select: 0 = fg, 1 = bg, 2 = border, 3 = ignored
cfg_data  in  16  RGB565 colour value
read_en  out  1  memory read strobe
read_addr  out  16  memory byte address
display_data  in  8  read data, valid READ_LAT cycles after read_en; MSB is the leftmost pixel
frame_start  out  1  one-cycle pulse, aligned with the first active pixel on the vga_* pins
vga_clk  out  1  equals clk_pix
vga_hsync, vga_vsync  out  1  registered syncs
vga_de  out  1  registered data enable
vga_r / vga_g / vga_b  out  5 / 6 / 5  registered colour

Behaviour:
- Clock and reset: one clock, clk_pix; rst_pix is synchronous, active-high.
- Counters: sx runs 0..H_TOTAL-1 and sy runs 0..V_TOTAL-1, with totals equal to RES+FP+SYNC+BP (defaults 1056 and 628). sy advances when sx wraps. Reset sets both to 0.
- Sync: hsync is active for sx in [H_RES+H_FP, H_RES+H_FP+H_SYNC); vsync likewise in sy. de = (sx<H_RES) and (sy<V_RES).
- Output latency: every vga_* output and frame_start reflects counter state one cycle earlier.
- Window offsets:
  - X_OFF = (H_RES-(BM_W<<SCALE))/2 (default 144); Y_OFF likewise (default 44).
  - Elaboration assertion: X_OFF >= READ_LAT+1, and the window fits inside the active area.
  - Inside the window: bx = (sx-X_OFF)>>SCALE, by = (sy-Y_OFF)>>SCALE.
- Fetch:
  - For each window row and each byte start S = X_OFF + k*(8<<SCALE), k = 0..BM_W/8-1, read_en pulses for 1 cycle at sx = S-READ_LAT-1.
  - read_addr = BASE_ADDR + by*(BM_W/8) + k, truncated to 16 bits.
  - No reads occur outside window rows or while en_q=0. read_addr holds its value between pulses.
- Shifter:
  - display_data is captured READ_LAT cycles after read_en into an 8-bit shift register, loaded on the edge where sx becomes S.
  - The register shifts left once every 1<<SCALE pixels; the current pixel is the MSB.
- Colour select, in priority order:
  - de=0: black.
  - en_q=0: black.
  - Outside the window: border.
  - Inside: fg if the pixel bit is 1, else bg.
- Config registers:
  - cfg_we writes a shadow register selected by cfg_sel; cfg_sel=3 is ignored.
  - Shadows copy to the active registers, and en is sampled into en_q, on the cycle the counters are at (0,0).
  - A write on that same cycle lands in the active register immediately.
- Reset values:
  - fg = yellow (0xF600), bg = blue (0x10CE), border = black (0x0000); shadows hold the same values.
  - en_q=0, read_en=0, read_addr=0, shift register=0, vga_de=0, rgb=0, frame_start=0.
  - vga_hsync and vga_vsync reset to their inactive level per polarity.
- Reset mid-frame restarts at (0,0); pending shadow writes are lost.

Decomposition:
- Package vdu_pkg holds:
  - typedef rgb565_t as a packed struct {r5, g6, b5};
  - enum cfg_sel_t {CFG_FG, CFG_BG, CFG_BORDER};
  - default colour constants;
  - a timing-parameter struct.
- Sub-module display_timing: parametrised sx/sy counters producing hsync, vsync, de, frame and line. It is reused by later VDU variants.

Test Plan:
- Reset held 3 cycles, defaults -> all outputs at reset values; after release, vga_hsync first rises at cycle 841, is high 128 cycles, and the period is 1056.
- Memory model returns addr[7:0], READ_LAT=1 -> on row sy=44, read_en pulses at sx=142, 206, ..., 590 with addresses 0..7; rows 44..51 repeat 0..7; sy=52 gives 8..15; last row 555 gives 504..511.
- Byte 0xA5 at address 0, en=1 -> pins show alternating 8-pixel runs fg, bg, fg, bg, bg, fg, bg, fg starting at sx=144 (pin cycle 145); sx 0..143 shows border.
- cfg write fg=0x07E0 mid-frame -> colour unchanged until the frame_start pulse, then green. A write with cfg_sel=3 changes nothing.
- en dropped at sy=300 -> frame finishes normally; the next frame is all black with no read_en, while syncs continue.
- READ_LAT=3, SCALE=2, BM_W=128 -> first read at sx=X_OFF-4, with X_OFF=144; pixel runs are 4 wide; image content matches the READ_LAT=1 case.
